// File: rtl/x7seg_pkg.sv
// x7seg_pkg
// Shared definitions for seven-segment display logic. The same constants
// are used by the display encoder and by the capture block.
//   - SEG_0 .. SEG_F : active-low segment patterns, bit6 = a ... bit0 = g
//   - SEG_BLANK      : all segments off
//   - AN_DIG0..3     : one-hot-low digit enables, AN_DIG0 = least-significant digit
//   - AN_NONE        : no digit enabled
//   - x7seg_sample_t : one {an, a_to_g} observation of the display bus
package x7seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h01;
  localparam logic [6:0] SEG_1 = 7'h4F;
  localparam logic [6:0] SEG_2 = 7'h12;
  localparam logic [6:0] SEG_3 = 7'h06;
  localparam logic [6:0] SEG_4 = 7'h4C;
  localparam logic [6:0] SEG_5 = 7'h24;
  localparam logic [6:0] SEG_6 = 7'h20;
  localparam logic [6:0] SEG_7 = 7'h0F;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h04;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h60;
  localparam logic [6:0] SEG_C = 7'h31;
  localparam logic [6:0] SEG_D = 7'h42;
  localparam logic [6:0] SEG_E = 7'h30;
  localparam logic [6:0] SEG_F = 7'h38;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_DIG0 = 4'hE;
  localparam logic [3:0] AN_DIG1 = 4'hD;
  localparam logic [3:0] AN_DIG2 = 4'hB;
  localparam logic [3:0] AN_DIG3 = 4'h7;
  localparam logic [3:0] AN_NONE = 4'hF;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } x7seg_sample_t;

  localparam x7seg_sample_t IDLE_SAMPLE = '{an: AN_NONE, seg: SEG_BLANK};

  // True only for exactly one enable driven low; blank and multi-low scans
  // are not a digit.
  function automatic logic an_is_selected(input logic [3:0] an);
    return (an == AN_DIG0) || (an == AN_DIG1) || (an == AN_DIG2) || (an == AN_DIG3);
  endfunction

  // Digit position of a one-hot-low enable; only meaningful when selected.
  function automatic logic [1:0] an_position(input logic [3:0] an);
    logic [1:0] pos;
    pos = 2'd0;
    case (an)
      AN_DIG1: pos = 2'd1;
      AN_DIG2: pos = 2'd2;
      AN_DIG3: pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/x7seg_capture_if.sv
// x7seg_capture_if
// Bundles the observed display bus and the captured-word results.
//   a_to_g[6:0]  active-low segments (bit6 = a ... bit0 = g)
//   an[3:0]      active-low digit enables, an[0] = least-significant digit
//   err_clr      synchronous clear of err_sticky
//   value[15:0]  last complete captured hex word
//   frame_valid  one-cycle pulse when value updates
//   digit_err    one-cycle pulse when an undecodable pattern is accepted
//   err_sticky   latched error flag
// master: the side that drives the display bus (source / testbench)
// slave : the capture block
interface x7seg_capture_if;
  logic [6:0]  a_to_g;
  logic [3:0]  an;
  logic        err_clr;
  logic [15:0] value;
  logic        frame_valid;
  logic        digit_err;
  logic        err_sticky;

  modport master (
    output a_to_g, an, err_clr,
    input  value, frame_valid, digit_err, err_sticky
  );

  modport slave (
    input  a_to_g, an, err_clr,
    output value, frame_valid, digit_err, err_sticky
  );
endinterface

// File: rtl/x7seg_lut.sv
// x7seg_lut
// Combinational reverse lookup from an active-low segment pattern to the
// hex nibble it displays.
//   pattern[6:0]  active-low segment pattern, bit6 = a ... bit0 = g
//   nibble[3:0]   decoded hex digit (0 when not valid)
//   valid         pattern is one of the 16 hex glyphs
module x7seg_lut
  import x7seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/x7seg_capture.sv
// x7seg_capture
// Watches a multiplexed, active-low 4-digit seven-segment bus and rebuilds
// the 16-bit hex word being displayed.
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   x7seg_capture_if.slave (a_to_g, an, err_clr in;
//         value, frame_valid, digit_err, err_sticky out)
// Parameter STABLE_CYCLES (2..255): identical consecutive samples needed
// before a digit is accepted.
// Macro X7SEG_SYNC_EN: when defined, a_to_g/an pass through a two-flop
// synchronizer ahead of the sample stage (for asynchronous sources, adds
// two cycles of latency). When undefined the sample stage is fed directly.
module x7seg_capture
  import x7seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  x7seg_capture_if.slave bus
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  x7seg_sample_t raw_in;
  x7seg_sample_t front;

  assign raw_in = '{an: bus.an, seg: bus.a_to_g};

`ifdef X7SEG_SYNC_EN
  x7seg_sample_t sync1_q, sync1_d;
  x7seg_sample_t sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_SAMPLE;
      sync2_q <= IDLE_SAMPLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign front = sync2_q;
`else
  assign front = raw_in;
`endif

  x7seg_sample_t samp_q, samp_d;
  x7seg_sample_t prev_q, prev_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   value_q, value_d;
  logic          frame_valid_q, frame_valid_d;
  logic          digit_err_q, digit_err_d;
  logic          err_sticky_q, err_sticky_d;

  logic          selected;
  logic          accept;
  logic [1:0]    pos;
  logic [3:0]    lut_nibble;
  logic          lut_valid;

  x7seg_lut u_lut (
    .pattern (samp_q.seg),
    .nibble  (lut_nibble),
    .valid   (lut_valid)
  );

  // The counter tracks how many consecutive samples (including samp_q)
  // carried the same selected {an, seg} pair. Acceptance fires on the one
  // transition into STABLE_MAX, so a digit held indefinitely is taken once.
  // A completed mask is flushed to value the cycle after it fills; the
  // flush uses the old shadow so a same-cycle write cannot leak into it.
  always_comb begin
    samp_d        = front;
    prev_d        = samp_q;
    selected      = an_is_selected(samp_q.an);
    pos           = an_position(samp_q.an);
    cnt_d         = 8'd0;
    shadow_d      = shadow_q;
    mask_d        = (mask_q == 4'hF) ? 4'h0 : mask_q;
    value_d       = value_q;
    frame_valid_d = (mask_q == 4'hF);
    digit_err_d   = 1'b0;

    if (selected) begin
      if ((samp_q == prev_q) && (cnt_q != 8'd0)) begin
        cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1;
      end else begin
        cnt_d = 8'd1;
      end
    end

    accept = (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX);

    if (frame_valid_d) begin
      value_d = shadow_q;
    end

    if (accept) begin
      if (lut_valid) begin
        shadow_d[{pos, 2'b00} +: 4] = lut_nibble;
        mask_d[pos]                 = 1'b1;
      end else begin
        digit_err_d = 1'b1;
      end
    end

    // A new error outranks a simultaneous clear request.
    err_sticky_d = digit_err_d | (err_sticky_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q        <= IDLE_SAMPLE;
      prev_q        <= IDLE_SAMPLE;
      cnt_q         <= 8'd0;
      shadow_q      <= 16'h0000;
      mask_q        <= 4'h0;
      value_q       <= 16'h0000;
      frame_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
    end else begin
      samp_q        <= samp_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      value_q       <= value_d;
      frame_valid_q <= frame_valid_d;
      digit_err_q   <= digit_err_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.err_sticky  = err_sticky_q;

endmodule

// File: tb/tb_x7seg_capture.sv
// tb_x7seg_capture
// Directed self-checking bench for x7seg_capture (STABLE_CYCLES = 4).
// Follows the X7SEG_SYNC_EN macro for the expected pipeline latency.
module tb_x7seg_capture;

  localparam int STABLE = 4;
`ifdef X7SEG_SYNC_EN
  localparam int EXP_LAT = STABLE + 4;
`else
  localparam int EXP_LAT = STABLE + 2;
`endif

  // Active-low glyphs for hex digits 0..F, typed in from the display table.
  localparam logic [6:0] PAT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic clk;
  logic rst;
  x7seg_capture_if bus ();

  x7seg_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int num_checks;
  int num_fail;
  int frame_cnt;
  int err_cnt;
  int frame_lat;
  int err_lat;
  logic sticky_seen;
  int f0;
  int e0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) frame_cnt <= frame_cnt + 1;
    if (bus.digit_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hold a bus value for n cycles; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [3:0] an_v, input logic [6:0] seg_v,
                               input int n);
    bus.an     = an_v;
    bus.a_to_g = seg_v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Same as applyStimulus but records, in cycles after the bus changed, the
  // first frame_valid and digit_err pulses and err_sticky at the error pulse.
  task automatic measureStimulus(input logic [3:0] an_v, input logic [6:0] seg_v,
                                 input int n);
    bus.an      = an_v;
    bus.a_to_g  = seg_v;
    frame_lat   = 0;
    err_lat     = 0;
    sticky_seen = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_lat == 0 && bus.frame_valid === 1'b1) frame_lat = i;
      if (err_lat == 0 && bus.digit_err === 1'b1) begin
        err_lat     = i;
        sticky_seen = bus.err_sticky;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    num_checks  = 0;
    num_fail    = 0;
    frame_cnt   = 0;
    err_cnt     = 0;
    frame_lat   = 0;
    err_lat     = 0;
    sticky_seen = 1'b0;
    rst         = 1'b1;
    bus.an      = 4'hF;
    bus.a_to_g  = 7'h7F;
    bus.err_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_value", bus.value, 32'h0);
    checkOutput("reset_frame_valid", bus.frame_valid, 32'h0);
    checkOutput("reset_digit_err", bus.digit_err, 32'h0);
    checkOutput("reset_err_sticky", bus.err_sticky, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame 1,2,3,4 most-significant first
    f0 = frame_cnt; e0 = err_cnt;
    applyStimulus(4'h7, PAT[1], 8);
    applyStimulus(4'hB, PAT[2], 8);
    applyStimulus(4'hD, PAT[3], 8);
    applyStimulus(4'hE, PAT[4], 8);
    applyStimulus(4'hF, 7'h7F, 6);
    checkOutput("frame1_count", frame_cnt - f0, 32'd1);
    checkOutput("frame1_value", bus.value, 32'h1234);
    checkOutput("frame1_errs", err_cnt - e0, 32'd0);
    checkOutput("frame1_sticky", bus.err_sticky, 32'h0);

    // Too-short run then blank: nothing accepted
    f0 = frame_cnt; e0 = err_cnt;
    applyStimulus(4'hE, PAT[0], STABLE - 1);
    applyStimulus(4'hF, 7'h7F, 6);
    checkOutput("short_frames", frame_cnt - f0, 32'd0);
    checkOutput("short_errs", err_cnt - e0, 32'd0);
    // Three other digits must not complete a frame if digit 0 was skipped
    applyStimulus(4'h7, PAT[9], 8);
    applyStimulus(4'hB, PAT[9], 8);
    applyStimulus(4'hD, PAT[9], 8);
    applyStimulus(4'hF, 7'h7F, 8);
    checkOutput("short_mask_empty", frame_cnt - f0, 32'd0);
    applyStimulus(4'hE, PAT[5], 8);
    applyStimulus(4'hF, 7'h7F, 6);
    checkOutput("short_then_frame_count", frame_cnt - f0, 32'd1);
    checkOutput("short_then_frame_value", bus.value, 32'h9995);

    // Undecodable pattern on digit 0
    f0 = frame_cnt; e0 = err_cnt;
    measureStimulus(4'hE, 7'h7F, 10);
    checkOutput("bad_err_count", err_cnt - e0, 32'd1);
    checkOutput("bad_err_latency", err_lat, EXP_LAT - 1);
    checkOutput("bad_sticky_at_pulse", sticky_seen, 32'h1);
    checkOutput("bad_sticky_held", bus.err_sticky, 32'h1);
    checkOutput("bad_no_frame", frame_cnt - f0, 32'd0);
    checkOutput("bad_value_kept", bus.value, 32'h9995);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    checkOutput("err_clr_clears", bus.err_sticky, 32'h0);
    // Clear held across a new error: set wins at the pulse
    bus.err_clr = 1'b1;
    measureStimulus(4'hD, 7'h7F, 10);
    checkOutput("setwin_err_count", err_cnt - e0, 32'd2);
    checkOutput("setwin_sticky_at_pulse", sticky_seen, 32'h1);
    checkOutput("setwin_cleared_after", bus.err_sticky, 32'h0);
    bus.err_clr = 1'b0;

    // Overwrite digit 0 (A then F) before completing A,b,C
    f0 = frame_cnt; e0 = err_cnt;
    applyStimulus(4'hE, PAT[10], 8);
    applyStimulus(4'hE, PAT[15], 8);
    applyStimulus(4'h7, PAT[10], 8);
    applyStimulus(4'hB, PAT[11], 8);
    applyStimulus(4'hD, PAT[12], 8);
    applyStimulus(4'hF, 7'h7F, 6);
    checkOutput("overwrite_frames", frame_cnt - f0, 32'd1);
    checkOutput("overwrite_value", bus.value, 32'hABCF);
    checkOutput("overwrite_errs", err_cnt - e0, 32'd0);

    // Reset in the middle of a frame
    applyStimulus(4'h7, PAT[1], 8);
    applyStimulus(4'hB, PAT[2], 8);
    applyStimulus(4'hD, PAT[3], 8);
    rst = 1'b1;
    #1;
    checkOutput("midrst_value_async", bus.value, 32'h0);
    checkOutput("midrst_frame_valid", bus.frame_valid, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    f0 = frame_cnt;
    applyStimulus(4'hE, PAT[8], 8);
    applyStimulus(4'hF, 7'h7F, 6);
    checkOutput("midrst_partial_discarded", frame_cnt - f0, 32'd0);
    applyStimulus(4'h7, PAT[5], 8);
    applyStimulus(4'hB, PAT[6], 8);
    applyStimulus(4'hD, PAT[7], 8);
    applyStimulus(4'hF, 7'h7F, 6);
    checkOutput("midrst_frames", frame_cnt - f0, 32'd1);
    checkOutput("midrst_value", bus.value, 32'h5678);

    // Two enables low: ignored, then latency of a full frame
    f0 = frame_cnt; e0 = err_cnt;
    applyStimulus(4'hC, PAT[4], 20);
    applyStimulus(4'hF, 7'h7F, 4);
    checkOutput("multilow_frames", frame_cnt - f0, 32'd0);
    checkOutput("multilow_errs", err_cnt - e0, 32'd0);
    applyStimulus(4'h7, PAT[1], 8);
    applyStimulus(4'hB, PAT[2], 8);
    applyStimulus(4'hD, PAT[3], 8);
    checkOutput("multilow_no_digit0", frame_cnt - f0, 32'd0);
    measureStimulus(4'hE, PAT[4], 20);
    checkOutput("latency_frame", frame_lat, EXP_LAT);
    checkOutput("latency_value", bus.value, 32'h1234);
    checkOutput("latency_frame_count", frame_cnt - f0, 32'd1);
    checkOutput("latency_errs", err_cnt - e0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/x7seg_capture.md
X7SEG_CAPTURE -- requirements
Module: x7seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive identical samples needed to accept a digit (legal range 2..255).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_to_g  input  7  segment bus, active-low; bit6=a ... bit0=g.
REQ-005 an  input  4  digit enables, active-low; an[0] = least-significant digit.
REQ-006 err_clr  input  1  synchronous clear of err_sticky.
REQ-007 value  output  16  last complete captured hex word; digit k in value[4k+3:4k].
REQ-008 frame_valid  output  1  one-cycle pulse when value updates.
REQ-009 digit_err  output  1  one-cycle pulse on acceptance of an undecodable pattern.
REQ-010 err_sticky  output  1  set by digit_err, held until err_clr or rst.

Function
REQ-011 The block SHALL register a_to_g and an into a sample stage; all decisions use sampled values (1-cycle input latency).
REQ-012 A sample is "selected" only when an is exactly one-hot-low (4'hE, 4'hD, 4'hB, 4'h7); all-ones (blank) or multi-low SHALL be ignored and SHALL zero the stability counter.
REQ-013 Stability counter SHALL increment while the selected {an, a_to_g} pair equals the previous sample, and reload to 1 on any change, saturating at STABLE_CYCLES.
REQ-014 A digit SHALL be accepted exactly once per stable run, on the cycle the counter first reaches STABLE_CYCLES; holding longer SHALL NOT re-accept.
REQ-015 Accepted pattern SHALL be decoded via the 16-entry active-low table: 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F 8=00 9=04 A=08 b=60 C=31 d=42 E=30 F=38 (hex, 7-bit).
REQ-016 Valid decode SHALL write the nibble into a shadow register at the selected position and set that position's bit in a 4-bit seen mask; rewriting an already-seen position overwrites the nibble.
REQ-017 Invalid pattern SHALL pulse digit_err the cycle after acceptance, set err_sticky, leave shadow and mask unchanged.
REQ-018 When the mask becomes 4'hF, the next cycle SHALL copy shadow to value, pulse frame_valid, clear mask to 0.
REQ-019 err_clr and a same-cycle new error: set SHALL win (err_sticky stays 1).
REQ-020 Minimum latency from first stable sample of the fourth digit to frame_valid SHALL be STABLE_CYCLES+2 cycles (+2 more with X7SEG_SYNC_EN).

Reset
REQ-021 rst SHALL asynchronously force value=16'h0000, frame_valid=0, digit_err=0, err_sticky=0, mask=0, shadow=0, counter=0, sample stage an=4'hF.
REQ-022 rst mid-frame SHALL discard partial digits; capture restarts from an empty mask after release.

Configuration
REQ-023 Macro X7SEG_SYNC_EN defined: a_to_g and an SHALL pass a two-flop synchronizer before the sample stage (+2 cycles latency, for asynchronous sources).
REQ-024 Macro undefined: inputs SHALL feed the sample stage directly; behaviour otherwise identical.

Structure
REQ-025 Shared package x7seg_pkg SHALL hold the 16 segment-pattern constants, the blank pattern 7'h7F, and the one-hot-low an constants, reused by the existing encoder.
REQ-026 Pattern-to-nibble lookup SHALL be one combinational sub-module x7seg_lut (in: 7-bit pattern; out: 4-bit nibble, valid).
REQ-027 Top block holds sample/sync stage, stability counter, mask/shadow, error logic.

Verification
REQ-028 Drive digits 1,2,3,4 on an 7,B,D,E, each 8 cycles -> one frame_valid, value=16'h1234, digit_err never set.
REQ-029 Hold an=E, a_to_g=01 for 3 cycles then blank (STABLE_CYCLES=4) -> nothing accepted, mask stays 0.
REQ-030 Scan digit 0 with a_to_g=7F (invalid) -> one digit_err pulse, err_sticky=1; pulse err_clr -> err_sticky=0.
REQ-031 Scan A,b,C, then an=E with 08 then 38 (each stable) -> value=16'hABCF, one frame_valid.
REQ-032 Assert rst after three digits accepted, release, scan 5,6,7,8 -> value=16'h5678; no frame from pre-reset digits.
REQ-033 Drive an=4'hC (two low) with valid pattern for 20 cycles -> no acceptance, no error; repeat both macro settings, checking latency per REQ-020.
